id_ex_fwd_reg: RTL and testbench
================================

// Module: id_ex_fwd_reg
// PURPOSE
// ID/EX pipeline register for the 5-stage RV32 core; captures decoded operands/controls each cycle.
// Generates the 2-bit forwarding selects for the downstream EX-stage 4:1 32-bit operand muxes.
// Raises a load-use stall request back to IF/ID.
// Implements stall (hold) and flush (bubble) control.
// PARAMETERS
// DATA_W  32  operand/immediate width
// REG_AW  5   register-address width
// PORTS
// clk_i           in   1       clock, all state updates on rising edge
// rst_i           in   1       synchronous reset, active-high
// stall_i         in   1       hold all registered state this cycle
// flush_i         in   1       load a bubble this cycle
// id_valid_i      in   1       ID stage holds a real instruction
// id_rs1_data_i   in   DATA_W  register-file read data, rs1
// id_rs2_data_i   in   DATA_W  register-file read data, rs2
// id_imm_i        in   DATA_W  sign-extended immediate
// id_rs1_i        in   REG_AW  rs1 address (also used for hazard check)
// id_rs2_i        in   REG_AW  rs2 address (also used for hazard check)
// id_rd_i         in   REG_AW  destination address
// id_ctrl_i       in   8       {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[2:0]}
// exmem_regwr_i   in   1       EX/MEM RegWrite
// exmem_rd_i      in   REG_AW  EX/MEM rd
// memwb_regwr_i   in   1       MEM/WB RegWrite
// memwb_rd_i      in   REG_AW  MEM/WB rd
// ex_valid_o      out  1       registered valid
// ex_rs1_data_o / ex_rs2_data_o / ex_imm_o  out DATA_W  registered operands
// ex_rs1_o / ex_rs2_o / ex_rd_o             out REG_AW  registered addresses
// ex_ctrl_o       out  8       registered controls
// fwd_a_o         out  2       select for operand-A mux
// fwd_b_o         out  2       select for operand-B mux
// stall_req_o     out  1       load-use hazard request
// BEHAVIOUR
// - Priority at each posedge: rst_i > flush_i > stall_i > load.
// - rst_i: every registered output clears to 0 (valid, data, addresses, ctrl) on the next edge.
// - flush_i: loads a bubble: valid=0, ctrl=0, data/addresses=0. flush_i together with stall_i flushes.
// - stall_i (no flush): all registers hold their values, bit-exact.
// - Otherwise: registers load the id_* inputs. ex_valid_o takes id_valid_i.
// - When id_valid_i=0 on a load, ctrl is forced to 0.
// - Latency: 1 cycle from ID input to ex_* output.
// - Mux select encoding:
//   - 00: ex_rs*_data (register file)
//   - 01: MEM/WB write-back data
//   - 10: EX/MEM ALU result
//   - 11: reserved, never driven
// - fwd_a_o is combinational from registered state:
//   - 10 if exmem_regwr_i & exmem_rd_i!=0 & exmem_rd_i==ex_rs1_o.
//   - else 01 if memwb_regwr_i & memwb_rd_i!=0 & memwb_rd_i==ex_rs1_o.
//   - else 00.
//   - EX/MEM wins when both stages match.
// - fwd_b_o: same rule using ex_rs2_o.
// - Both selects are 00 whenever ex_valid_o=0. Both are 00 during and right after reset.
// - stall_req_o (combinational) = ex_valid_o & MemRead & ex_rd_o!=0 & (ex_rd_o==id_rs1_i | ex_rd_o==id_rs2_i).
// - stall_req_o is 0 when id_valid_i=0.
// - Register x0 never forwards and never causes a stall.
// - Reset mid-stall: rst_i overrides stall_i; state clears.
// TESTING
// - Reset, then drive rst_i=1 for one edge -> all ex_* =0, fwd_a/b=00, stall_req=0.
// - Load rs1=3, rs1_data=0x11, imm=0xFFFFFFF0 -> next cycle ex_rs1_o=3, ex_rs1_data_o=0x11, ex_imm_o=0xFFFFFFF0.
// - Then assert stall_i for 3 cycles with new inputs -> outputs unchanged for all 3 cycles.
// - ex_rs1=5, ex_rs2=5; exmem rd=5 regwr=1; memwb rd=5 regwr=1 -> fwd_a=fwd_b=10.
// - Then drop exmem_regwr -> 01. Then set rd=0 on both stages -> 00.
// - Load with MemRead=1, rd=7; next ID has rs2=7 -> stall_req=1. Assert flush_i -> next cycle valid=0, ctrl=0, stall_req=0.
// - Assert flush_i and stall_i together with valid data -> bubble loaded, not hold.
// - Assert rst_i during stall -> state cleared.

Source files
------------

// File: rtl/id_ex_fwd_reg_if.sv
// ID/EX boundary bundle: ID-stage inputs, hazard-unit inputs and the EX-side results.
// The ID side drives through the master modport; the pipeline register uses slave.
interface id_ex_fwd_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              stall_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [DATA_W-1:0] id_rs1_data_i;
  logic [DATA_W-1:0] id_rs2_data_i;
  logic [DATA_W-1:0] id_imm_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic [7:0]        id_ctrl_i;
  logic              exmem_regwr_i;
  logic [REG_AW-1:0] exmem_rd_i;
  logic              memwb_regwr_i;
  logic [REG_AW-1:0] memwb_rd_i;

  logic              ex_valid_o;
  logic [DATA_W-1:0] ex_rs1_data_o;
  logic [DATA_W-1:0] ex_rs2_data_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [REG_AW-1:0] ex_rs1_o;
  logic [REG_AW-1:0] ex_rs2_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic [7:0]        ex_ctrl_o;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic              stall_req_o;

  modport master (
    output stall_i, flush_i, id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_ctrl_i,
           exmem_regwr_i, exmem_rd_i, memwb_regwr_i, memwb_rd_i,
    input  ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o, fwd_a_o, fwd_b_o, stall_req_o
  );

  modport slave (
    input  stall_i, flush_i, id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_ctrl_i,
           exmem_regwr_i, exmem_rd_i, memwb_regwr_i, memwb_rd_i,
    output ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o, fwd_a_o, fwd_b_o, stall_req_o
  );
endinterface

// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with EX operand-forward selects and load-use stall request.
// Edge priority: reset, then flush (bubble), then stall (hold), then load.
module id_ex_fwd_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  id_ex_fwd_reg_if.slave  bus
);

  localparam int CTRL_MEMREAD = 5;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;

  logic              valid_q;
  logic [DATA_W-1:0] rs1_data_q;
  logic [DATA_W-1:0] rs2_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic [7:0]        ctrl_q;

  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              load_use;

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      valid_q    <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
    end else if (!bus.stall_i) begin
      valid_q    <= bus.id_valid_i;
      rs1_data_q <= bus.id_rs1_data_i;
      rs2_data_q <= bus.id_rs2_data_i;
      imm_q      <= bus.id_imm_i;
      rs1_q      <= bus.id_rs1_i;
      rs2_q      <= bus.id_rs2_i;
      rd_q       <= bus.id_rd_i;
      // A non-instruction must never write, read or store in later stages.
      ctrl_q     <= bus.id_valid_i ? bus.id_ctrl_i : 8'h00;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic              valid,
                                         input logic [REG_AW-1:0] src,
                                         input logic              exmem_wr,
                                         input logic [REG_AW-1:0] exmem_rd,
                                         input logic              memwb_wr,
                                         input logic [REG_AW-1:0] memwb_rd);
    logic [1:0] sel;
    sel = SEL_RF;
    if (valid) begin
      // The younger EX/MEM result shadows MEM/WB when both target the same register.
      if (exmem_wr && (exmem_rd != '0) && (exmem_rd == src))
        sel = SEL_EXMEM;
      else if (memwb_wr && (memwb_rd != '0) && (memwb_rd == src))
        sel = SEL_MEMWB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(valid_q, rs1_q, bus.exmem_regwr_i, bus.exmem_rd_i,
                    bus.memwb_regwr_i, bus.memwb_rd_i);
    fwd_b = fwd_sel(valid_q, rs2_q, bus.exmem_regwr_i, bus.exmem_rd_i,
                    bus.memwb_regwr_i, bus.memwb_rd_i);
  end

  always_comb begin
    load_use = 1'b0;
    if (valid_q && ctrl_q[CTRL_MEMREAD] && (rd_q != '0) && bus.id_valid_i)
      load_use = (rd_q == bus.id_rs1_i) || (rd_q == bus.id_rs2_i);
  end

  assign bus.ex_valid_o    = valid_q;
  assign bus.ex_rs1_data_o = rs1_data_q;
  assign bus.ex_rs2_data_o = rs2_data_q;
  assign bus.ex_imm_o      = imm_q;
  assign bus.ex_rs1_o      = rs1_q;
  assign bus.ex_rs2_o      = rs2_q;
  assign bus.ex_rd_o       = rd_q;
  assign bus.ex_ctrl_o     = ctrl_q;
  assign bus.fwd_a_o       = fwd_a;
  assign bus.fwd_b_o       = fwd_b;
  assign bus.stall_req_o   = load_use;

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Bench for id_ex_fwd_reg: directed scenarios plus randomized traffic against a
// cycle-level reference model of the pipeline register and hazard rules.
module tb_id_ex_fwd_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_fwd_reg_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_fwd_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // reference model of the EX-side registered view
  logic        m_valid;
  logic [31:0] m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [7:0]  m_ctrl;

  task automatic model_clear();
    m_valid = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
  endtask

  // one clock edge; model follows rst > flush > stall > load
  task automatic tick();
    @(posedge clk);
    if (rst || bus.flush_i) model_clear();
    else if (!bus.stall_i) begin
      m_valid = bus.id_valid_i;
      m_rs1d  = bus.id_rs1_data_i;
      m_rs2d  = bus.id_rs2_data_i;
      m_imm   = bus.id_imm_i;
      m_rs1   = bus.id_rs1_i;
      m_rs2   = bus.id_rs2_i;
      m_rd    = bus.id_rd_i;
      m_ctrl  = bus.id_valid_i ? bus.id_ctrl_i : 8'h00;
    end
    #1;
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (!m_valid) return 2'b00;
    if (bus.exmem_regwr_i && bus.exmem_rd_i != 0 && bus.exmem_rd_i == src) return 2'b10;
    if (bus.memwb_regwr_i && bus.memwb_rd_i != 0 && bus.memwb_rd_i == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_stall();
    return m_valid && m_ctrl[5] && m_rd != 0 && bus.id_valid_i &&
           (m_rd == bus.id_rs1_i || m_rd == bus.id_rs2_i);
  endfunction

  task automatic drive_idle();
    bus.stall_i = 0; bus.flush_i = 0; bus.id_valid_i = 0;
    bus.id_rs1_data_i = 0; bus.id_rs2_data_i = 0; bus.id_imm_i = 0;
    bus.id_rs1_i = 0; bus.id_rs2_i = 0; bus.id_rd_i = 0; bus.id_ctrl_i = 0;
    bus.exmem_regwr_i = 0; bus.exmem_rd_i = 0; bus.memwb_regwr_i = 0; bus.memwb_rd_i = 0;
  endtask

  task automatic drive_random_id();
    bus.id_valid_i    = ($urandom_range(0, 3) != 0);
    bus.id_rs1_data_i = $urandom;
    bus.id_rs2_data_i = $urandom;
    bus.id_imm_i      = $urandom;
    bus.id_rs1_i      = 5'($urandom_range(0, 7));
    bus.id_rs2_i      = 5'($urandom_range(0, 7));
    bus.id_rd_i       = 5'($urandom_range(0, 7));
    bus.id_ctrl_i     = 8'($urandom);
  endtask

  task automatic test_reset();
    drive_idle();
    bus.id_valid_i = 1; bus.id_ctrl_i = 8'hFF; bus.id_rs1_data_i = 32'hDEAD_BEEF;
    bus.id_rs1_i = 3; bus.id_rd_i = 3;
    bus.exmem_regwr_i = 1; bus.exmem_rd_i = 0;
    rst = 1;
    tick();
    tick();
    checks++;
    if (bus.ex_valid_o !== 1'b0 || bus.ex_ctrl_o !== 8'h00 || bus.ex_rs1_data_o !== 32'h0 ||
        bus.ex_rs2_data_o !== 32'h0 || bus.ex_imm_o !== 32'h0 || bus.ex_rs1_o !== 5'd0 ||
        bus.ex_rs2_o !== 5'd0 || bus.ex_rd_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_regs: valid=%b ctrl=%h rs1d=%h imm=%h rd=%0d required all zero",
               bus.ex_valid_o, bus.ex_ctrl_o, bus.ex_rs1_data_o, bus.ex_imm_o, bus.ex_rd_o);
    end
    checks++;
    if (bus.fwd_a_o !== 2'b00 || bus.fwd_b_o !== 2'b00 || bus.stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: fwd_a=%b fwd_b=%b stall_req=%b required 00 00 0",
               bus.fwd_a_o, bus.fwd_b_o, bus.stall_req_o);
    end
    rst = 0;
    drive_idle();
  endtask

  task automatic test_load();
    drive_idle();
    bus.id_valid_i = 1; bus.id_rs1_i = 3; bus.id_rs1_data_i = 32'h11;
    bus.id_imm_i = 32'hFFFF_FFF0; bus.id_rs2_i = 9; bus.id_rd_i = 12; bus.id_ctrl_i = 8'h8A;
    tick();
    checks++;
    if (bus.ex_rs1_o !== 5'd3 || bus.ex_rs1_data_o !== 32'h11 || bus.ex_imm_o !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL load_basic: rs1=%0d rs1d=%h imm=%h required 3 00000011 fffffff0",
               bus.ex_rs1_o, bus.ex_rs1_data_o, bus.ex_imm_o);
    end
    checks++;
    if (bus.ex_valid_o !== 1'b1 || bus.ex_ctrl_o !== 8'h8A || bus.ex_rd_o !== 5'd12) begin
      errors++;
      $display("FAIL load_ctrl: valid=%b ctrl=%h rd=%0d required 1 8a 12",
               bus.ex_valid_o, bus.ex_ctrl_o, bus.ex_rd_o);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive_random_id();
      bus.stall_i = 1;
      tick();
      checks++;
      if (bus.ex_rs1_o !== 5'd3 || bus.ex_rs1_data_o !== 32'h11 || bus.ex_imm_o !== 32'hFFFF_FFF0 ||
          bus.ex_ctrl_o !== 8'h8A || bus.ex_valid_o !== 1'b1 || bus.ex_rd_o !== 5'd12 ||
          bus.ex_rs2_o !== 5'd9) begin
        errors++;
        $display("FAIL stall_hold[%0d]: rs1=%0d rs1d=%h imm=%h ctrl=%h valid=%b required 3 11 fffffff0 8a 1",
                 i, bus.ex_rs1_o, bus.ex_rs1_data_o, bus.ex_imm_o, bus.ex_ctrl_o, bus.ex_valid_o);
      end
    end
    drive_idle();
  endtask

  task automatic test_forwarding();
    drive_idle();
    bus.id_valid_i = 1; bus.id_rs1_i = 5; bus.id_rs2_i = 5; bus.id_rd_i = 1;
    tick();
    bus.id_valid_i = 0;
    bus.exmem_regwr_i = 1; bus.exmem_rd_i = 5; bus.memwb_regwr_i = 1; bus.memwb_rd_i = 5;
    #1;
    checks++;
    if (bus.fwd_a_o !== 2'b10 || bus.fwd_b_o !== 2'b10) begin
      errors++;
      $display("FAIL fwd_exmem: a=%b b=%b required 10 10", bus.fwd_a_o, bus.fwd_b_o);
    end
    bus.exmem_regwr_i = 0;
    #1;
    checks++;
    if (bus.fwd_a_o !== 2'b01 || bus.fwd_b_o !== 2'b01) begin
      errors++;
      $display("FAIL fwd_memwb: a=%b b=%b required 01 01", bus.fwd_a_o, bus.fwd_b_o);
    end
    bus.exmem_regwr_i = 1; bus.exmem_rd_i = 0; bus.memwb_rd_i = 0;
    #1;
    checks++;
    if (bus.fwd_a_o !== 2'b00 || bus.fwd_b_o !== 2'b00) begin
      errors++;
      $display("FAIL fwd_rd_zero: a=%b b=%b required 00 00", bus.fwd_a_o, bus.fwd_b_o);
    end
    // x0 source operand must not forward even when a stage writes x0
    bus.id_valid_i = 1; bus.id_rs1_i = 0; bus.id_rs2_i = 6;
    tick();
    bus.exmem_rd_i = 6; bus.memwb_regwr_i = 1; bus.memwb_rd_i = 0;
    #1;
    checks++;
    if (bus.fwd_a_o !== 2'b00 || bus.fwd_b_o !== 2'b10) begin
      errors++;
      $display("FAIL fwd_x0_split: a=%b b=%b required 00 10", bus.fwd_a_o, bus.fwd_b_o);
    end
    drive_idle();
  endtask

  task automatic test_load_use();
    drive_idle();
    bus.id_valid_i = 1; bus.id_rd_i = 7; bus.id_ctrl_i = 8'b0110_0000; bus.id_rs1_i = 2;
    tick();
    bus.id_rs1_i = 4; bus.id_rs2_i = 7;
    #1;
    checks++;
    if (bus.stall_req_o !== 1'b1) begin
      errors++;
      $display("FAIL load_use_hit: stall_req=%b required 1", bus.stall_req_o);
    end
    bus.id_valid_i = 0;
    #1;
    checks++;
    if (bus.stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL load_use_idvalid0: stall_req=%b required 0", bus.stall_req_o);
    end
    bus.id_valid_i = 1;
    bus.flush_i = 1;
    tick();
    bus.flush_i = 0;
    #1;
    checks++;
    if (bus.ex_valid_o !== 1'b0 || bus.ex_ctrl_o !== 8'h00 || bus.stall_req_o !== 1'b0 ||
        bus.ex_rd_o !== 5'd0) begin
      errors++;
      $display("FAIL load_use_flush: valid=%b ctrl=%h stall_req=%b rd=%0d required 0 00 0 0",
               bus.ex_valid_o, bus.ex_ctrl_o, bus.stall_req_o, bus.ex_rd_o);
    end
    // load into x0 never stalls
    bus.id_rd_i = 0; bus.id_ctrl_i = 8'b0010_0000; bus.id_rs1_i = 0; bus.id_rs2_i = 0;
    tick();
    checks++;
    if (bus.stall_req_o !== 1'b0 || bus.ex_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL load_use_x0: stall_req=%b valid=%b required 0 1", bus.stall_req_o, bus.ex_valid_o);
    end
    drive_idle();
  endtask

  task automatic test_flush_with_stall();
    drive_idle();
    bus.id_valid_i = 1; bus.id_rs1_data_i = 32'hA5A5_0001; bus.id_rd_i = 9; bus.id_ctrl_i = 8'hC3;
    tick();
    bus.id_rs1_data_i = 32'h1234_5678; bus.id_rd_i = 10;
    bus.flush_i = 1; bus.stall_i = 1;
    tick();
    checks++;
    if (bus.ex_valid_o !== 1'b0 || bus.ex_ctrl_o !== 8'h00 || bus.ex_rs1_data_o !== 32'h0 ||
        bus.ex_rd_o !== 5'd0) begin
      errors++;
      $display("FAIL flush_stall: valid=%b ctrl=%h rs1d=%h rd=%0d required 0 00 0 0",
               bus.ex_valid_o, bus.ex_ctrl_o, bus.ex_rs1_data_o, bus.ex_rd_o);
    end
    drive_idle();
  endtask

  task automatic test_reset_during_stall();
    drive_idle();
    bus.id_valid_i = 1; bus.id_imm_i = 32'h7777_0000; bus.id_rs2_i = 6; bus.id_ctrl_i = 8'h21;
    tick();
    bus.stall_i = 1;
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (bus.ex_valid_o !== 1'b0 || bus.ex_imm_o !== 32'h0 || bus.ex_rs2_o !== 5'd0 ||
        bus.ex_ctrl_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_in_stall: valid=%b imm=%h rs2=%0d ctrl=%h required all zero",
               bus.ex_valid_o, bus.ex_imm_o, bus.ex_rs2_o, bus.ex_ctrl_o);
    end
    drive_idle();
  endtask

  task automatic test_random();
    drive_idle();
    for (int n = 0; n < 400; n++) begin
      drive_random_id();
      bus.stall_i = ($urandom_range(0, 3) == 0);
      bus.flush_i = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 49) == 0);
      tick();
      rst = 0;
      checks++;
      if (bus.ex_valid_o !== m_valid || bus.ex_ctrl_o !== m_ctrl || bus.ex_rs1_data_o !== m_rs1d ||
          bus.ex_rs2_data_o !== m_rs2d || bus.ex_imm_o !== m_imm || bus.ex_rs1_o !== m_rs1 ||
          bus.ex_rs2_o !== m_rs2 || bus.ex_rd_o !== m_rd) begin
        errors++;
        $display("FAIL rand_regs[%0d]: got v=%b c=%h a=%h b=%h i=%h %0d/%0d/%0d required v=%b c=%h a=%h b=%h i=%h %0d/%0d/%0d",
                 n, bus.ex_valid_o, bus.ex_ctrl_o, bus.ex_rs1_data_o, bus.ex_rs2_data_o, bus.ex_imm_o,
                 bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_rd_o,
                 m_valid, m_ctrl, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd);
      end
      bus.exmem_regwr_i = $urandom_range(0, 1);
      bus.exmem_rd_i    = 5'($urandom_range(0, 7));
      bus.memwb_regwr_i = $urandom_range(0, 1);
      bus.memwb_rd_i    = 5'($urandom_range(0, 7));
      bus.id_valid_i    = ($urandom_range(0, 3) != 0);
      bus.id_rs1_i      = 5'($urandom_range(0, 7));
      bus.id_rs2_i      = 5'($urandom_range(0, 7));
      #1;
      checks++;
      if (bus.fwd_a_o !== exp_fwd(m_rs1) || bus.fwd_b_o !== exp_fwd(m_rs2) ||
          bus.stall_req_o !== exp_stall()) begin
        errors++;
        $display("FAIL rand_comb[%0d]: a=%b b=%b stall=%b required a=%b b=%b stall=%b",
                 n, bus.fwd_a_o, bus.fwd_b_o, bus.stall_req_o,
                 exp_fwd(m_rs1), exp_fwd(m_rs2), exp_stall());
      end
    end
    drive_idle();
  endtask

  initial begin
    model_clear();
    drive_idle();
    test_reset();
    test_load();
    test_stall();
    test_forwarding();
    test_load_use();
    test_flush_with_stall();
    test_reset_during_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
